// File: rtl/mmio_access_ctrl.sv
// Load/store decode for EX/MEM: data-memory strobes are combinational, and I/O accesses use a
// request/ack handshake on one of NUM_CH channels while the pipeline stalls. MMIO_TIMEOUT_EN adds a WAIT timeout.
module mmio_access_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int IO_LSB      = 10,
    parameter int NUM_CH      = 4,
    parameter int CH_LSB      = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [31:0]       instr_i,
    input  logic [ADDR_W-1:0] alu_result_i,
    input  logic [31:0]       store_data_i,
    input  logic [31:0]       io_rdata_i,
    input  logic [NUM_CH-1:0] io_ack_i,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              mem_or_io_to_reg_o,
    output logic              io_req_o,
    output logic              io_we_o,
    output logic [NUM_CH-1:0] io_sel_o,
    output logic [CH_LSB-1:0] io_addr_o,
    output logic [31:0]       io_wdata_o,
    output logic [31:0]       io_rdata_o,
    output logic              stall_o,
    output logic              err_o
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_nxt;

    logic              is_load, is_store, io_hit, io_access, ch_ok;
    logic [CH_W-1:0]   ch_idx, ch_q, ch_nxt;
    logic              we_q, we_nxt;
    logic [NUM_CH-1:0] sel_nxt;
    logic              ack_sel, latch, capture, err_nxt;
    logic              unused;

    assign is_load   = valid_i && (instr_i[6:0] == 7'h03);
    assign is_store  = valid_i && (instr_i[6:0] == 7'h23);
    assign io_hit    = &alu_result_i[ADDR_W-1:IO_LSB];
    assign io_access = (is_load || is_store) && io_hit;
    assign ch_idx    = alu_result_i[CH_LSB +: CH_W];
    assign unused    = ^{instr_i[31:7], alu_result_i};

    assign mem_read_o         = is_load && !io_hit;
    assign mem_write_o        = is_store && !io_hit;
    assign mem_or_io_to_reg_o = is_load;
    assign stall_o = !rst_i && (((state == IDLE) && io_access) || (state == WAIT));

    // A power-of-two channel count leaves no index that could fall outside the window.
    generate
        if (NUM_CH == (1 << CH_W)) begin : g_full
            assign ch_ok = 1'b1;
        end else begin : g_part
            assign ch_ok = (ch_idx < CH_W'(NUM_CH));
        end
    endgenerate

    // io_sel_o is the one-hot of the latched channel throughout WAIT, so it doubles as the ack mask.
    assign ack_sel = |(io_ack_i & io_sel_o);

`ifdef MMIO_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] to_cnt;
    logic             timeout_hit;

    assign timeout_hit = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            to_cnt <= '0;
        else if (state != WAIT)
            to_cnt <= '0;
        else if (!ack_sel)
            to_cnt <= to_cnt + CNT_W'(1);
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        capture   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (io_access) begin
                    latch = 1'b1;
                    if (ch_ok) begin
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (ack_sel) begin
                    capture   = !we_q;
                    state_nxt = DONE;
                end
`ifdef MMIO_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end
`endif
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ch_nxt = latch ? ch_idx : ch_q;
    assign we_nxt = latch ? is_store : we_q;

    always_comb begin
        sel_nxt = '0;
        for (int i = 0; i < NUM_CH; i++)
            sel_nxt[i] = (ch_nxt == CH_W'(i));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ch_q       <= '0;
            we_q       <= 1'b0;
            io_req_o   <= 1'b0;
            io_we_o    <= 1'b0;
            io_sel_o   <= '0;
            io_addr_o  <= '0;
            io_wdata_o <= '0;
            io_rdata_o <= '0;
            err_o      <= 1'b0;
        end else begin
            ch_q     <= ch_nxt;
            we_q     <= we_nxt;
            io_req_o <= (state_nxt == WAIT);
            io_we_o  <= (state_nxt == WAIT) && we_nxt;
            io_sel_o <= (state_nxt == WAIT) ? sel_nxt : '0;
            err_o    <= err_nxt;
            if (latch) begin
                io_addr_o  <= alu_result_i[CH_LSB-1:0];
                io_wdata_o <= store_data_i;
            end
            if (capture)
                io_rdata_o <= io_rdata_i;
            else if (err_nxt)
                io_rdata_o <= '0;
        end
    end
endmodule

// File: doc/mmio_access_ctrl.md
# mmio_access_ctrl

Parametrised memory/I-O access controller for the EX/MEM stage of the RISC-V core. It decodes load/store instructions into data-memory or memory-mapped I/O accesses and splits the I/O window into `NUM_CH` peripheral channels. Unlike the single-cycle decode it replaces, I/O accesses run through a request/acknowledge handshake with per-access stall. Data-memory accesses remain single-cycle and combinational.

## Interface
Parameters:
- `ADDR_W`, 32, address width of `alu_result_i`
- `IO_LSB`, 10, lowest address bit of the I/O window tag; an access is I/O when `alu_result_i[ADDR_W-1:IO_LSB]` is all ones
- `NUM_CH`, 4, number of I/O channels, 1..16
- `CH_LSB`, 4, lowest address bit of the channel index; index field is `CH_W = $clog2(NUM_CH)` bits wide, min 1
- `TIMEOUT_CYC`, 255, maximum cycles in WAIT (used only with `MMIO_TIMEOUT_EN`)

Ports:
- `clk_i` in 1: single clock, rising edge
- `rst_i` in 1: asynchronous, active-high reset
- `valid_i` in 1: EX/MEM slot holds a real instruction (0 = bubble/flush)
- `instr_i` in 32: instruction in EX/MEM
- `alu_result_i` in `ADDR_W`: effective address
- `store_data_i` in 32: store data
- `io_rdata_i` in 32: shared peripheral read bus, sampled on ack
- `io_ack_i` in `NUM_CH`: per-channel acknowledge
- `mem_read_o`, `mem_write_o` out 1: data-memory strobes
- `mem_or_io_to_reg_o` out 1: load writeback select
- `io_req_o` out 1, `io_we_o` out 1, `io_sel_o` out `NUM_CH` (one-hot): registered I/O request
- `io_addr_o` out `CH_LSB`: offset within channel
- `io_wdata_o` out 32: registered store data
- `io_rdata_o` out 32: captured load data
- `stall_o` out 1: freeze pipeline
- `err_o` out 1: one-cycle error pulse

## Operation
- A load is `valid_i & instr_i[6:0]==7'h03`. A store is `valid_i & instr_i[6:0]==7'h23`. `io_hit` means the address tag is all ones.
- `mem_read_o = load & !io_hit` and `mem_write_o = store & !io_hit`. Both are combinational in every state.
- `mem_or_io_to_reg_o = load`.
- FSM states are IDLE, WAIT and DONE.
- IDLE:
  - If `(load|store) & io_hit`, latch channel index, `alu_result_i[CH_LSB-1:0]`, `store_data_i` and the store flag.
  - If the index is below `NUM_CH`, go to WAIT.
  - If the index is at or above `NUM_CH` (decode error), go directly to DONE with `err_o`=1 and `io_rdata_o`=0. No request is issued.
- WAIT:
  - `io_req_o`=1, `io_sel_o` = one-hot of the latched channel, `io_we_o` = store flag. These are stable for the whole WAIT.
  - `io_ack_i` bits of unselected channels are ignored.
  - On `io_ack_i[ch]`: if the access is a load, capture `io_rdata_i` into `io_rdata_o`; then go to DONE.
- DONE: lasts one cycle, with `io_req_o`=0. Go to IDLE unconditionally. The instruction still presented this cycle is not restarted.
- `io_rdata_o` holds its value until the next capture.
- `stall_o = (IDLE & (load|store) & io_hit) | WAIT`. It is forced to 0 while `rst_i`=1.

## Timing
- Reset values:
  - state IDLE
  - `io_req_o`, `io_we_o`, `err_o` = 0
  - `io_sel_o` = 0
  - `io_addr_o` = 0
  - `io_wdata_o`, `io_rdata_o` = 0
  - internal timeout counter = 0
- Minimum I/O latency (ack in the first WAIT cycle):
  - cycle 0: detect, stall
  - cycle 1: WAIT, request, stall
  - cycle 2: DONE, pipeline advances
  - Result: 2 stall cycles.
- Memory accesses add 0 stall cycles.
- Ack asserted in the same cycle as detect (IDLE) is ignored. The peripheral must hold ack until it sees a request.
- Reset asserted mid-access (WAIT or DONE) returns to IDLE immediately and drops `io_req_o`. The access is abandoned.
- A `valid_i` drop during WAIT does not cancel the access; the access completes normally.

## Configuration
- `MMIO_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on WAIT entry and increments each WAIT cycle without ack.
  - When it reaches `TIMEOUT_CYC`, go to DONE with `err_o`=1 and `io_rdata_o`=0.
  - Ack in that same cycle wins over timeout.
- Not defined: no counter exists; WAIT persists until ack; `err_o` is raised only by decode error.

## Test plan
- Load `0x0000_1000` → `mem_read_o`=1 in the same cycle, `stall_o`=0, `io_req_o` never asserted.
- Load `0xFFFF_FC20` (`NUM_CH`=4, so channel 2), ack at first WAIT cycle with `io_rdata_i`=`0x0000_00A5` → `stall_o` high for 2 cycles, `io_sel_o`=`4'b0100`, `io_rdata_o`=`0xA5` in DONE.
- Store `0xFFFF_FC14` with data `0x1234`, ack delayed 5 cycles → `io_we_o`=1, `io_addr_o`=4, `io_wdata_o`=`0x1234` held 6 cycles, 7 stall cycles total.
- Ack on channel 0 while channel 3 is selected → ignored, FSM stays in WAIT.
- With `MMIO_TIMEOUT_EN`, `TIMEOUT_CYC`=8, no ack → DONE after 8 WAIT cycles, `err_o` pulses 1 cycle, `io_rdata_o`=0.
- `rst_i` raised during WAIT → `io_req_o`/`stall_o` drop at once; the next load to the same address restarts from IDLE.
